// File: rtl/inst_issue_queue_pkg.sv
// Shared sizing constants and handshake-decode helpers for the decode-to-issue queue.
// Includes the all-zero reset bundle.
package inst_issue_queue_pkg;

    localparam int unsigned DsToIsBusWd = 64;
    localparam int unsigned IqDepth     = 4;

    localparam logic [DsToIsBusWd-1:0] IqResetBundle = '0;

    typedef enum logic [1:0] {
        IqHold,
        IqPush,
        IqPop,
        IqPushPop
    } iq_op_e;

    function automatic iq_op_e iq_decode_op(input logic push, input logic pop);
        iq_op_e op;
        op = iq_op_e'({pop, push});
        return op;
    endfunction

endpackage

// File: rtl/inst_issue_queue.sv
// Decoupling FIFO between decode (ID) and issue (IS) with valid/allowin handshakes.
// Level-sensitive flush empties the queue and masks the head.
module inst_issue_queue
    import inst_issue_queue_pkg::*;
#(
    parameter int unsigned WIDTH = DsToIsBusWd,
    parameter int unsigned DEPTH = IqDepth,
    parameter int unsigned PTR_W = $clog2(DEPTH),
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             iq_flush,
    input  logic             ds_to_iq_valid,
    input  logic [WIDTH-1:0] ds_to_iq_bus,
    output logic             iq_allowin,
    output logic             iq_to_is_valid,
    output logic [WIDTH-1:0] iq_to_is_bus,
    input  logic             is_allowin,
    output logic [CNT_W-1:0] iq_count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic   push;
    logic   pop;
    iq_op_e op;

    // allowin depends only on registered occupancy, so a full queue refuses even while popping.
    always_comb begin
        iq_allowin     = (count_q < CNT_W'(DEPTH));
        iq_to_is_valid = (count_q != '0) && !iq_flush;
        iq_to_is_bus   = mem_q[rd_ptr_q];
        iq_count       = count_q;
        push           = ds_to_iq_valid && iq_allowin && !iq_flush;
        pop            = iq_to_is_valid && is_allowin;
        op             = iq_decode_op(push, pop);
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (iq_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            unique case (op)
                IqPush: begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    count_d  = count_q + CNT_W'(1);
                end
                IqPop: begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    count_d  = count_q - CNT_W'(1);
                end
                IqPushPop: begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= WIDTH'(IqResetBundle);
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= ds_to_iq_bus;
            end
        end
    end

endmodule

// File: tb/tb_inst_issue_queue.sv
// Self-checking bench: table-driven fill/drain, hand-written corner sequences,
// and random traffic against a queue-based reference model.
module tb_inst_issue_queue;

    localparam int unsigned W     = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;

    logic             clk;
    logic             resetn;
    logic             iq_flush;
    logic             ds_to_iq_valid;
    logic [W-1:0]     ds_to_iq_bus;
    logic             iq_allowin;
    logic             iq_to_is_valid;
    logic [W-1:0]     iq_to_is_bus;
    logic             is_allowin;
    logic [CNT_W-1:0] iq_count;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mq[$];

    inst_issue_queue #(
        .WIDTH(W),
        .DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .iq_flush      (iq_flush),
        .ds_to_iq_valid(ds_to_iq_valid),
        .ds_to_iq_bus  (ds_to_iq_bus),
        .iq_allowin    (iq_allowin),
        .iq_to_is_valid(iq_to_is_valid),
        .iq_to_is_bus  (iq_to_is_bus),
        .is_allowin    (is_allowin),
        .iq_count      (iq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         f;
        logic         v;
        logic [W-1:0] b;
        logic         ia;
        logic         e_allow;
        logic         e_valid;
        logic [W-1:0] e_bus;
        int           e_count;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic f, input logic v, input logic [W-1:0] b, input logic ia);
        iq_flush       = f;
        ds_to_iq_valid = v;
        ds_to_iq_bus   = b;
        is_allowin     = ia;
        #1;
    endtask

    // Applies one cycle: checks outputs against the model, clocks, then advances the model.
    task automatic step(input logic f, input logic v, input logic [W-1:0] b, input logic ia);
        logic m_allow, m_valid, m_push, m_pop, inv_ok;
        logic [1:0] diff;
        set_in(f, v, b, ia);
        m_allow = (mq.size() < DEPTH);
        m_valid = (mq.size() != 0) && !f;
        chk("allowin", 32'(iq_allowin), 32'(m_allow));
        chk("valid", 32'(iq_to_is_valid), 32'(m_valid));
        chk("count", 32'(iq_count), 32'(mq.size()));
        if (m_valid) chk("head_bus", 32'(iq_to_is_bus), 32'(mq[0]));
        diff   = dut.wr_ptr_q - dut.rd_ptr_q;
        inv_ok = (dut.count_q <= DEPTH) &&
                 ((dut.count_q == DEPTH) ? (dut.wr_ptr_q == dut.rd_ptr_q)
                                         : (32'(dut.count_q) == 32'(diff)));
        chk("ptr_invariant", 32'(inv_ok), 32'd1);
        m_push = v && m_allow && !f;
        m_pop  = m_valid && ia;
        @(posedge clk);
        if (f) begin
            mq.delete();
        end else begin
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(b);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b0, '0, 1'b0);
        resetn = 1'b0;
        mq.delete();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #1;
    endtask

    vec_t tbl[10];

    initial begin
        resetn = 1'b0;
        set_in(1'b0, 1'b0, '0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_allowin", 32'(iq_allowin), 32'd1);
        chk("rst_valid", 32'(iq_to_is_valid), 32'd0);
        resetn = 1'b1;
        #1;
        chk("post_rst_count", 32'(iq_count), 32'd0);
        chk("post_rst_bus", 32'(iq_to_is_bus), 32'd0);

        // Fill to full with IS stalled, offer a fifth, then drain in order.
        tbl[0] = '{1'b0, 1'b1, 16'hA1, 1'b0, 1'b1, 1'b0, 16'h0,  0};
        tbl[1] = '{1'b0, 1'b1, 16'hA2, 1'b0, 1'b1, 1'b1, 16'hA1, 1};
        tbl[2] = '{1'b0, 1'b1, 16'hA3, 1'b0, 1'b1, 1'b1, 16'hA1, 2};
        tbl[3] = '{1'b0, 1'b1, 16'hA4, 1'b0, 1'b1, 1'b1, 16'hA1, 3};
        tbl[4] = '{1'b0, 1'b1, 16'hA5, 1'b0, 1'b0, 1'b1, 16'hA1, 4};
        tbl[5] = '{1'b0, 1'b0, 16'h0,  1'b1, 1'b0, 1'b1, 16'hA1, 4};
        tbl[6] = '{1'b0, 1'b0, 16'h0,  1'b1, 1'b1, 1'b1, 16'hA2, 3};
        tbl[7] = '{1'b0, 1'b0, 16'h0,  1'b1, 1'b1, 1'b1, 16'hA3, 2};
        tbl[8] = '{1'b0, 1'b0, 16'h0,  1'b1, 1'b1, 1'b1, 16'hA4, 1};
        tbl[9] = '{1'b0, 1'b0, 16'h0,  1'b1, 1'b1, 1'b0, 16'h0,  0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].f, tbl[i].v, tbl[i].b, tbl[i].ia);
            chk("tbl_allowin", 32'(iq_allowin), 32'(tbl[i].e_allow));
            chk("tbl_valid", 32'(iq_to_is_valid), 32'(tbl[i].e_valid));
            chk("tbl_count", 32'(iq_count), 32'(tbl[i].e_count));
            if (tbl[i].e_valid) chk("tbl_bus", 32'(iq_to_is_bus), 32'(tbl[i].e_bus));
            step(tbl[i].f, tbl[i].v, tbl[i].b, tbl[i].ia);
        end

        // Streaming: one in, one out each cycle after the first.
        for (int i = 0; i < 20; i++) begin
            set_in(1'b0, 1'b1, W'(i), 1'b1);
            if (i > 0) begin
                chk("stream_count", 32'(iq_count), 32'd1);
                chk("stream_lag", 32'(iq_to_is_bus), 32'(i - 1));
            end
            step(1'b0, 1'b1, W'(i), 1'b1);
        end
        step(1'b0, 1'b0, '0, 1'b1);

        // Flush with content: same-cycle push dropped, no pop, then a fresh push becomes head.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, W'(16'h30 + i), 1'b0);
        set_in(1'b1, 1'b1, 16'hBB, 1'b1);
        chk("flush_valid", 32'(iq_to_is_valid), 32'd0);
        step(1'b1, 1'b1, 16'hBB, 1'b1);
        set_in(1'b0, 1'b0, '0, 1'b1);
        chk("post_flush_count", 32'(iq_count), 32'd0);
        chk("post_flush_valid", 32'(iq_to_is_valid), 32'd0);
        step(1'b0, 1'b1, 16'hCC, 1'b0);
        set_in(1'b0, 1'b0, '0, 1'b0);
        chk("after_flush_head", 32'(iq_to_is_bus), 32'hCC);
        step(1'b0, 1'b0, '0, 1'b1);

        // Full with simultaneous pop: push refused, allowin returns next cycle.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, W'(16'h40 + i), 1'b0);
        set_in(1'b0, 1'b1, 16'hDD, 1'b1);
        chk("full_allowin", 32'(iq_allowin), 32'd0);
        step(1'b0, 1'b1, 16'hDD, 1'b1);
        set_in(1'b0, 1'b1, 16'hDD, 1'b0);
        chk("full_pop_count", 32'(iq_count), 32'd3);
        chk("full_pop_allowin", 32'(iq_allowin), 32'd1);
        step(1'b0, 1'b1, 16'hDD, 1'b0);
        chk("refill_count", 32'(iq_count), 32'd4);

        // Asynchronous reset mid-stream with count 3.
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, W'(16'h50 + i), 1'b0);
        chk("pre_rst_count", 32'(iq_count), 32'd3);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_count", 32'(iq_count), 32'd0);
        chk("async_rst_valid", 32'(iq_to_is_valid), 32'd0);
        chk("async_rst_allowin", 32'(iq_allowin), 32'd1);
        chk("async_rst_bus", 32'(iq_to_is_bus), 32'd0);
        @(negedge clk);
        do_reset();
        @(negedge clk);

        // Random traffic against the reference queue.
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(99) < 5), 1'($urandom), W'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
